// File: rtl/gamepad_pkg.sv
// Shared definitions for the gamepad poll sequencer: FSM encoding, button
// bit positions and default timing constants (50 MHz system clock).
package gamepad_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_BIT_LOW,
      ST_BIT_HIGH,
      ST_DONE
   } state_t;

   localparam int unsigned BTN_A      = 0;
   localparam int unsigned BTN_B      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;

   localparam int unsigned DEF_LATCH_CYCLES       = 600;
   localparam int unsigned DEF_HALF_BIT_CYCLES    = 300;
   localparam int unsigned DEF_POLL_PERIOD_CYCLES = 833333;

endpackage

// File: rtl/gamepad_poll_sequencer_timer.sv
// Free-running auto-poll interval counter; held at zero while disabled and
// pulses tick for one cycle every PERIOD enabled cycles.
module poll_timer #(
   parameter int unsigned PERIOD = 833333
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int unsigned W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [W-1:0] LAST = W'(PERIOD - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (!en || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/gamepad_poll_sequencer.sv
// Serial gamepad poller: latch strobe, eight clocked bit reads, active-high
// button snapshot with valid/changed pulses and a one-deep request queue.
module gamepad_poll_sequencer
   import gamepad_pkg::*;
#(
   parameter int unsigned LATCH_CYCLES       = DEF_LATCH_CYCLES,
   parameter int unsigned HALF_BIT_CYCLES    = DEF_HALF_BIT_CYCLES,
   parameter int unsigned POLL_PERIOD_CYCLES = DEF_POLL_PERIOD_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       poll_req,
   input  logic       auto_en,
   input  logic       pad_data,
   output logic       pad_latch,
   output logic       pad_clk,
   output logic [7:0] buttons,
   output logic       valid,
   output logic       changed,
   output logic       busy
);

   localparam int unsigned MAX_PHASE = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
   localparam int unsigned CW        = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
   localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_BIT_CYCLES - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          pending;
   logic          tick;
   logic          start;

   poll_timer #(.PERIOD(POLL_PERIOD_CYCLES)) u_timer (
      .clk   (clk),
      .reset (reset),
      .en    (auto_en),
      .tick  (tick)
   );

   assign start = poll_req || (auto_en && tick);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         pending   <= 1'b0;
         pad_latch <= 1'b0;
         pad_clk   <= 1'b0;
         buttons   <= '0;
         valid     <= 1'b0;
         changed   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         valid   <= 1'b0;
         changed <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_LATCH;
                  cnt       <= '0;
                  pad_latch <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            ST_LATCH: begin
               if (start) pending <= 1'b1;
               if (cnt == LATCH_LAST) begin
                  cnt       <= '0;
                  bit_idx   <= '0;
                  pad_latch <= 1'b0;
                  state     <= ST_BIT_LOW;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_BIT_LOW: begin
               if (start) pending <= 1'b1;
               if (cnt == HALF_LAST) begin
                  cnt            <= '0;
                  shift[bit_idx] <= ~pad_data;
                  pad_clk        <= 1'b1;
                  state          <= ST_BIT_HIGH;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_BIT_HIGH: begin
               if (start) pending <= 1'b1;
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  pad_clk <= 1'b0;
                  if (bit_idx == 3'd7) begin
                     // outputs are registered, so the DONE-cycle results are loaded on entry
                     buttons <= shift;
                     valid   <= 1'b1;
                     changed <= (shift != buttons);
                     state   <= ST_DONE;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     state   <= ST_BIT_LOW;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DONE: begin
               // a request landing in DONE is served immediately, as if queued
               if (pending || start) begin
                  pending   <= 1'b0;
                  cnt       <= '0;
                  pad_latch <= 1'b1;
                  state     <= ST_LATCH;
               end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
